// File: rtl/alu2_issue_seq.sv
// Command sequencer in front of the 8-bit alu2 slice ALU: buffers commands, runs the
// ALU write/strobe handshake, returns result and flags, and keeps the chained carry.
module alu2_issue_seq #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [2:0] s_opcode,
  input  logic [7:0] s_operand0,
  input  logic [7:0] s_operand1,
  input  logic       s_chain,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_result,
  output logic       m_carry,
  output logic       m_zero,
  output logic       m_sign,
  output logic       flag_carry,
  output logic       error,
  output logic       alu_enable,
  output logic       alu_write,
  output logic       alu_strobe,
  output logic [2:0] alu_opcode,
  output logic [7:0] alu_operand0,
  output logic [7:0] alu_operand1,
  output logic       alu_carryin,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_sign,
  input  logic       alu_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(TIMEOUT + 1);
  localparam int CW = 20;
  localparam logic [AW:0] PTR_ONE = 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_ARM    = 3'd2;
  localparam logic [2:0] ST_FIRE   = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_COMMIT = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  logic [CW-1:0] fifo_mem [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cmd_q;
  logic [2:0]    state_q, state_d;
  logic          phase_q, phase_d;
  logic [BW-1:0] busy_q, busy_d;
  logic          seen_low_q, seen_low_d;
  logic [7:0]    result_q, result_d;
  logic [2:0]    flags_q, flags_d;
  logic          flag_carry_q, flag_carry_d;
  logic          error_q, error_d;
  logic          enable_q;
  logic [1:0]    startup_q;
  logic          fifo_empty, fifo_full, startup_done, push, pop;

  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign startup_done = (startup_q == 2'd2);
  // Popping straight out of COMMIT keeps the issue period at 11 cycles.
  assign pop  = !fifo_empty && startup_done &&
                ((state_q == ST_IDLE) || ((state_q == ST_COMMIT) && m_ready));
  assign s_ready = !fifo_full || pop;
  assign push    = s_valid && s_ready;

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {s_opcode, s_operand0, s_operand1, s_chain};
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    busy_d       = busy_q;
    seen_low_d   = seen_low_q;
    result_d     = result_q;
    flags_d      = flags_q;
    flag_carry_d = flag_carry_q;
    error_d      = error_q;
    case (state_q)
      ST_IDLE: if (pop) begin
        state_d = ST_LOAD;
        phase_d = 1'b0;
      end
      ST_LOAD: begin
        phase_d = !phase_q;
        if (phase_q) state_d = ST_ARM;
      end
      ST_ARM: begin
        phase_d = !phase_q;
        if (phase_q) state_d = ST_FIRE;
      end
      ST_FIRE: begin
        state_d    = ST_WAIT;
        busy_d     = BW'(1);
        seen_low_d = 1'b0;
      end
      ST_WAIT: begin
        if (alu_ready && seen_low_q) begin
          result_d = alu_result;
          state_d  = ST_COMMIT;
        end else if ((alu_ready && (busy_q == BW'(1))) || (busy_q == BW'(TIMEOUT))) begin
          state_d = ST_ERR;
        end else begin
          busy_d = busy_q + BW'(1);
          if (!alu_ready) seen_low_d = 1'b1;
          // Flags are only valid while the ALU's top slice is evaluating.
          if (busy_q == BW'(4)) flags_d = {alu_carry, alu_zero, alu_sign};
        end
      end
      ST_COMMIT: if (m_ready) begin
        flag_carry_d = flags_q[2];
        state_d      = pop ? ST_LOAD : ST_IDLE;
        phase_d      = 1'b0;
      end
      ST_ERR: begin
        error_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cmd_q        <= '0;
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      busy_q       <= '0;
      seen_low_q   <= 1'b0;
      result_q     <= '0;
      flags_q      <= '0;
      flag_carry_q <= 1'b0;
      error_q      <= 1'b0;
      enable_q     <= 1'b0;
      startup_q    <= '0;
    end else begin
      enable_q <= 1'b1;
      if (!startup_done) startup_q <= startup_q + 2'd1;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        cmd_q    <= fifo_mem[rd_ptr_q[AW-1:0]];
      end
      state_q      <= state_d;
      phase_q      <= phase_d;
      busy_q       <= busy_d;
      seen_low_q   <= seen_low_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      flag_carry_q <= flag_carry_d;
      error_q      <= error_d;
    end
  end

  assign m_valid      = (state_q == ST_COMMIT);
  assign m_result     = result_q;
  assign m_carry      = flags_q[2];
  assign m_zero       = flags_q[1];
  assign m_sign       = flags_q[0];
  assign flag_carry   = flag_carry_q;
  assign error        = error_q;
  assign alu_enable   = enable_q;
  assign alu_write    = (state_q == ST_LOAD);
  assign alu_strobe   = (state_q == ST_FIRE);
  assign alu_opcode   = cmd_q[19:17];
  assign alu_operand0 = cmd_q[16:9];
  assign alu_operand1 = cmd_q[8:1];
  // flag_carry cannot change between LOAD and WAIT, so this stays stable for the ALU.
  assign alu_carryin  = cmd_q[0] & flag_carry_q;

endmodule

// File: tb/tb_alu2_issue_seq.sv
// Directed bench for alu2_issue_seq with a small behavioural ALU that goes busy for
// four cycles after each strobe and presents flags only on its last busy cycle.
module tb_alu2_issue_seq;
  logic       aclk = 1'b0;
  logic       aresetn = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [2:0] s_opcode = '0;
  logic [7:0] s_operand0 = '0;
  logic [7:0] s_operand1 = '0;
  logic       s_chain = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_result;
  logic       m_carry, m_zero, m_sign, flag_carry, error;
  logic       alu_enable, alu_write, alu_strobe, alu_carryin;
  logic [2:0] alu_opcode;
  logic [7:0] alu_operand0, alu_operand1, alu_result;
  logic       alu_carry, alu_zero, alu_sign, alu_ready;

  localparam logic [2:0] OP_ADC = 3'b001, OP_AND = 3'b011, OP_ORR = 3'b100;
  localparam logic [2:0] OP_EOR = 3'b101, OP_SEL = 3'b110, OP_SEH = 3'b111;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  alu2_issue_seq #(.DEPTH(4), .TIMEOUT(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_opcode(s_opcode),
    .s_operand0(s_operand0), .s_operand1(s_operand1), .s_chain(s_chain),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
    .m_carry(m_carry), .m_zero(m_zero), .m_sign(m_sign),
    .flag_carry(flag_carry), .error(error),
    .alu_enable(alu_enable), .alu_write(alu_write), .alu_strobe(alu_strobe),
    .alu_opcode(alu_opcode), .alu_operand0(alu_operand0), .alu_operand1(alu_operand1),
    .alu_carryin(alu_carryin), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .alu_ready(alu_ready)
  );

  // Behavioural ALU
  function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic ci);
    case (op)
      3'b001:  return {1'b0, a} + {1'b0, b} + {8'd0, ci};
      3'b010:  return {1'b0, a} + {1'b0, ~b} + {8'd0, ci};
      3'b011:  return {1'b0, a & b};
      3'b100:  return {1'b0, a | b};
      3'b101:  return {1'b0, a ^ b};
      3'b110:  return {1'b0, b};
      3'b111:  return {1'b0, a};
      default: return 9'd0;
    endcase
  endfunction

  logic       alu_tie = 1'b0;
  logic       rdy_q;
  int         busy_n;
  logic [7:0] mres;
  logic       mc, mz, ms;
  logic [8:0] fn_out;

  assign fn_out = alu_fn(alu_opcode, alu_operand0, alu_operand1, alu_carryin);

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_q <= 1'b1; busy_n <= 0; mres <= '0; mc <= 1'b0; mz <= 1'b0; ms <= 1'b0;
    end else if (busy_n > 0) begin
      busy_n <= busy_n - 1;
      if (busy_n == 1) rdy_q <= 1'b1;
    end else if (alu_strobe && alu_enable && !alu_tie) begin
      mres <= fn_out[7:0]; mc <= fn_out[8]; mz <= (fn_out[7:0] == 8'd0); ms <= fn_out[7];
      rdy_q <= 1'b0; busy_n <= 4;
    end
  end

  assign alu_ready  = alu_tie | rdy_q;
  assign alu_result = mres;
  assign alu_carry  = (busy_n == 1) & mc;
  assign alu_zero   = (busy_n == 1) & mz;
  assign alu_sign   = (busy_n == 1) & ms;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic ch);
    int n;
    n = 0;
    while (!s_ready && n < 100) begin @(negedge aclk); n++; end
    check_eq("send_ready", 64'(s_ready), 64'd1);
    if (!s_ready) return;
    s_valid = 1'b1; s_opcode = op; s_operand0 = a; s_operand1 = b; s_chain = ch;
    @(posedge aclk);
    @(negedge aclk);
    s_valid = 1'b0;
    $display("push op=%0d a=0x%02h b=0x%02h chain=%0d", op, a, b, ch);
  endtask

  task automatic expect_result(input string tag, input logic [7:0] r, input logic [2:0] czs,
                               output int at_cyc);
    int n;
    n = 0;
    while (!m_valid && n < 100) begin @(negedge aclk); n++; end
    at_cyc = cyc;
    check_eq({tag, "_valid"}, 64'(m_valid), 64'd1);
    check_eq({tag, "_res"}, 64'(m_result), 64'(r));
    check_eq({tag, "_czs"}, 64'({m_carry, m_zero, m_sign}), 64'(czs));
    $display("result %s: 0x%02h czs=%03b at cycle %0d", tag, m_result,
             {m_carry, m_zero, m_sign}, at_cyc);
    if (m_valid) begin
      @(posedge aclk);
      @(negedge aclk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, t0, t1, t2, t3, n, cnt;
    logic seen_mv;

    #2 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check_eq("rst_s_ready", 64'(s_ready), 64'd1);
    check_eq("rst_outs", {m_valid, m_result, m_carry, m_zero, m_sign, flag_carry, error,
                          alu_enable, alu_write, alu_strobe, alu_opcode, alu_operand0,
                          alu_operand1, alu_carryin}, 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check_eq("enable_on", 64'(alu_enable), 64'd1);
    repeat (3) @(negedge aclk);

    // Single ADC and its latency
    send(OP_ADC, 8'h7F, 8'h01, 1'b0);
    c0 = cyc;
    expect_result("adc1", 8'h80, 3'b001, t0);
    check_eq("adc1_lat", 64'(t0 - c0), 64'd11);
    check_eq("adc1_fc", 64'(flag_carry), 64'd0);

    // Carry chain
    send(OP_ADC, 8'hFF, 8'h01, 1'b0);
    expect_result("chain1", 8'h00, 3'b110, t0);
    check_eq("chain1_fc", 64'(flag_carry), 64'd1);
    send(OP_ADC, 8'h00, 8'h00, 1'b1);
    expect_result("chain2", 8'h01, 3'b000, t0);
    check_eq("chain2_fc", 64'(flag_carry), 64'd0);

    // Operand routing, issued back to back
    send(OP_SEL, 8'h12, 8'h34, 1'b0);
    send(OP_SEH, 8'h12, 8'h34, 1'b0);
    send(OP_AND, 8'hF0, 8'h3C, 1'b0);
    send(OP_EOR, 8'hAA, 8'hAA, 1'b0);
    expect_result("sel", 8'h34, 3'b000, t0);
    expect_result("seh", 8'h12, 3'b000, t1);
    expect_result("and", 8'h30, 3'b000, t2);
    expect_result("eor", 8'h00, 3'b010, t3);
    check_eq("throughput", 64'(t2 - t1), 64'd11);

    // Back-pressure: one command in COMMIT plus four buffered fills the FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(OP_ADC, 8'(i * 3), 8'h20, 1'b0);
    repeat (20) @(negedge aclk);
    check_eq("bp_full", 64'(s_ready), 64'd0);
    check_eq("bp_hold", 64'({m_valid, m_result}), 64'({1'b1, 8'h20}));
    m_ready = 1'b1;
    #1;
    fork
      send(OP_ADC, 8'd15, 8'h20, 1'b0);
      for (int i = 0; i < 6; i++) begin
        int tt;
        expect_result($sformatf("bp%0d", i), 8'(8'h20 + i * 3), 3'b000, tt);
      end
    join

    // Timeout: ALU never reports busy
    send(OP_ADC, 8'hFF, 8'h01, 1'b0);
    expect_result("pre_to", 8'h00, 3'b110, t0);
    alu_tie = 1'b1;
    send(OP_ADC, 8'h01, 8'h01, 1'b0);
    n = 0;
    seen_mv = 1'b0;
    while (!error && n < 60) begin
      @(negedge aclk);
      n++;
      if (m_valid) seen_mv = 1'b1;
    end
    check_eq("to_error", 64'(error), 64'd1);
    check_eq("to_no_valid", 64'(seen_mv), 64'd0);
    check_eq("to_fc_kept", 64'(flag_carry), 64'd1);
    alu_tie = 1'b0;
    send(OP_ADC, 8'h01, 8'h01, 1'b1);
    expect_result("post_to", 8'h03, 3'b000, t0);
    check_eq("err_sticky", 64'(error), 64'd1);

    // Reset during WAIT with two commands still queued
    send(OP_ADC, 8'h01, 8'h02, 1'b0);
    send(OP_ORR, 8'h0F, 8'hF0, 1'b0);
    send(OP_EOR, 8'h0F, 8'h01, 1'b0);
    n = 0;
    while (alu_ready && n < 40) begin @(negedge aclk); n++; end
    check_eq("rm_busy", 64'(alu_ready), 64'd0);
    aresetn = 1'b0;
    #1;
    check_eq("rm_s_ready", 64'(s_ready), 64'd1);
    check_eq("rm_outs", {m_valid, m_result, m_carry, m_zero, m_sign, flag_carry, error,
                         alu_enable, alu_write, alu_strobe, alu_opcode, alu_operand0,
                         alu_operand1, alu_carryin}, 64'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    c0 = cyc;
    send(OP_ADC, 8'h40, 8'h02, 1'b0);
    while (!alu_strobe && (cyc - c0) < 40) @(negedge aclk);
    check_eq("rm_fire_time", 64'((cyc - c0) >= 7 && (cyc - c0) < 40), 64'd1);
    expect_result("rm_new", 8'h42, 3'b000, t0);
    cnt = 0;
    repeat (40) begin
      @(negedge aclk);
      if (m_valid) cnt++;
    end
    check_eq("rm_dropped", 64'(cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
